// File: rtl/cpu_core_if.sv
// Observation bundle for cpu_core: exports the key combinational datapath nets.
// master drives (core), slave observes (bench/monitor); all signals are outputs of the core.
interface cpu_core_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
);
    logic [WORDSIZE-1:0]         cpu_reading_rf_data_a;
    logic [WORDSIZE-1:0]         cpu_reading_rf_data_b;
    logic [WORDSIZE-1:0]         cpu_reading_dm_data_out;
    logic [WORDSIZE-1:0]         cpu_reading_mux_0_out;
    logic [WORDSIZE-1:0]         cpu_reading_mux_1_out;
    logic [WORDSIZE-1:0]         cpu_reading_mux_2_out;
    logic [INSTRUCTION_SIZE-1:0] cpu_reading_im_instr;
    logic [WORDSIZE-1:0]         cpu_reading_pc_addr;

    modport master (
        output cpu_reading_rf_data_a,
        output cpu_reading_rf_data_b,
        output cpu_reading_dm_data_out,
        output cpu_reading_mux_0_out,
        output cpu_reading_mux_1_out,
        output cpu_reading_mux_2_out,
        output cpu_reading_im_instr,
        output cpu_reading_pc_addr
    );

    modport slave (
        input cpu_reading_rf_data_a,
        input cpu_reading_rf_data_b,
        input cpu_reading_dm_data_out,
        input cpu_reading_mux_0_out,
        input cpu_reading_mux_1_out,
        input cpu_reading_mux_2_out,
        input cpu_reading_im_instr,
        input cpu_reading_pc_addr
    );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle RV64 datapath (ld, sd, add, sub, addi, beq) with internal ROM, regfile, RAM.
// Ports: cpu_clk, cpu_rst (async active-high), obs (cpu_core_if.master observation nets).
module cpu_core #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int IMEM_DEPTH       = 64,
    parameter int DMEM_DEPTH       = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    cpu_core_if.master    obs
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [WORDSIZE-1:0]         pc;
    logic [WORDSIZE-1:0]         rf [32];
    logic [WORDSIZE-1:0]         dmem [DMEM_DEPTH];
    logic [INSTRUCTION_SIZE-1:0] instr;

    function automatic logic [INSTRUCTION_SIZE-1:0] rom_word(
        input logic [IAW-1:0] idx
    );
        logic [INSTRUCTION_SIZE-1:0] w;
        case (idx)
            IAW'(0): w = 32'h00803083;
            IAW'(1): w = 32'h00103823;
            IAW'(2): w = 32'h00108133;
            IAW'(3): w = 32'h401101B3;
            IAW'(4): w = 32'h00518213;
            IAW'(5): w = 32'hFFD20293;
            default: w = 32'h00000013;
        endcase
        return w;
    endfunction

    assign instr = rom_word(pc[IAW+1:2]);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    logic is_ld;
    logic is_sd;
    logic is_add;
    logic is_sub;
    logic is_addi;
    logic is_beq;

    assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
    assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000)
                     && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000)
                     && (funct7 == 7'b0100000);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);

    logic [WORDSIZE-1:0] imm_i;
    logic [WORDSIZE-1:0] imm_s;
    logic [WORDSIZE-1:0] imm_b;
    logic [WORDSIZE-1:0] imm;

    assign imm_i = {{(WORDSIZE-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(WORDSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(WORDSIZE-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

    always_comb begin
        imm = imm_i;
        unique case (1'b1)
            is_sd:   imm = imm_s;
            is_beq:  imm = imm_b;
            default: imm = imm_i;
        endcase
    end

    // x0 is hardwired to zero on read; its storage is never written.
    logic [WORDSIZE-1:0] rf_a;
    logic [WORDSIZE-1:0] rf_b;

    assign rf_a = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rf_b = (rs2 == 5'd0) ? '0 : rf[rs2];

    logic [WORDSIZE-1:0] mux_0;
    logic [WORDSIZE-1:0] alu;
    logic                zero;

    assign mux_0 = (is_add || is_sub || is_beq) ? rf_b : imm;
    assign alu   = (is_sub || is_beq) ? (rf_a - mux_0) : (rf_a + mux_0);
    assign zero  = (alu == '0);

    // Doubleword addressing: low three address bits are dropped.
    logic [DAW-1:0]      dm_idx;
    logic [WORDSIZE-1:0] dm_out;

    assign dm_idx = alu[DAW+2:3];
    assign dm_out = dmem[dm_idx];

    logic [WORDSIZE-1:0] mux_1;
    logic [WORDSIZE-1:0] mux_2;
    logic                reg_we;

    assign mux_1  = is_ld ? dm_out : alu;
    assign mux_2  = (is_beq && zero) ? (pc + imm_b) : (pc + WORDSIZE'(4));
    assign reg_we = is_ld || is_add || is_sub || is_addi;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
            for (int k = 0; k < DMEM_DEPTH; k++) begin
                dmem[k] <= WORDSIZE'(k * 16);
            end
        end else begin
            pc <= mux_2;
            if (reg_we && (rd != 5'd0)) begin
                rf[rd] <= mux_1;
            end
            if (is_sd) begin
                dmem[dm_idx] <= rf_b;
            end
        end
    end

    assign obs.cpu_reading_rf_data_a   = rf_a;
    assign obs.cpu_reading_rf_data_b   = rf_b;
    assign obs.cpu_reading_dm_data_out = dm_out;
    assign obs.cpu_reading_mux_0_out   = mux_0;
    assign obs.cpu_reading_mux_1_out   = mux_1;
    assign obs.cpu_reading_mux_2_out   = mux_2;
    assign obs.cpu_reading_im_instr    = instr;
    assign obs.cpu_reading_pc_addr     = pc;

    logic unused_bits;
    assign unused_bits = ^{pc[WORDSIZE-1:IAW+2], pc[1:0],
                           alu[WORDSIZE-1:DAW+3], alu[2:0]};
endmodule

// File: tb/tb_cpu_core.sv
// Directed testbench for cpu_core: program trace, nop, async reset, beq.
// Drives cpu_clk/cpu_rst, observes the exported datapath nets via cpu_core_if.
module tb_cpu_core;
    logic cpu_clk;
    logic cpu_rst;
    int   errors;
    int   checks;

    cpu_core_if #(.WORDSIZE(64), .INSTRUCTION_SIZE(32)) obs_if ();

    cpu_core dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .obs     (obs_if.master)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_pc got %h exp %h", obs_if.cpu_reading_pc_addr, 64'h0);
        end
        checks++;
        if (obs_if.cpu_reading_im_instr !== 32'h00803083) begin
            errors++;
            $display("FAIL reset_instr got %h exp %h", obs_if.cpu_reading_im_instr, 32'h00803083);
        end
        checks++;
        if (obs_if.cpu_reading_mux_0_out !== 64'h8) begin
            errors++;
            $display("FAIL reset_mux0 got %h exp %h", obs_if.cpu_reading_mux_0_out, 64'h8);
        end
        checks++;
        if (obs_if.cpu_reading_dm_data_out !== 64'h10) begin
            errors++;
            $display("FAIL reset_dm got %h exp %h", obs_if.cpu_reading_dm_data_out, 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_mux_1_out !== 64'h10) begin
            errors++;
            $display("FAIL reset_mux1 got %h exp %h", obs_if.cpu_reading_mux_1_out, 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_mux_2_out !== 64'h4) begin
            errors++;
            $display("FAIL reset_mux2 got %h exp %h", obs_if.cpu_reading_mux_2_out, 64'h4);
        end
    endtask

    task automatic test_ld_sd();
        step();
        checks++;
        if (dut.rf[1] !== 64'h10) begin
            errors++;
            $display("FAIL ld_x1 got %h exp %h", dut.rf[1], 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h4) begin
            errors++;
            $display("FAIL sd_pc got %h exp %h", obs_if.cpu_reading_pc_addr, 64'h4);
        end
        checks++;
        if (obs_if.cpu_reading_im_instr !== 32'h00103823) begin
            errors++;
            $display("FAIL sd_instr got %h exp %h", obs_if.cpu_reading_im_instr, 32'h00103823);
        end
        checks++;
        if (obs_if.cpu_reading_rf_data_b !== 64'h10) begin
            errors++;
            $display("FAIL sd_rfb got %h exp %h", obs_if.cpu_reading_rf_data_b, 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_mux_0_out !== 64'h10) begin
            errors++;
            $display("FAIL sd_mux0 got %h exp %h", obs_if.cpu_reading_mux_0_out, 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_mux_2_out !== 64'h8) begin
            errors++;
            $display("FAIL sd_mux2 got %h exp %h", obs_if.cpu_reading_mux_2_out, 64'h8);
        end
        step();
        checks++;
        if (dut.dmem[2] !== 64'h10) begin
            errors++;
            $display("FAIL sd_ram2 got %h exp %h", dut.dmem[2], 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_rf_data_a !== 64'h10 || obs_if.cpu_reading_rf_data_b !== 64'h10) begin
            errors++;
            $display("FAIL add_ops got %h/%h exp %h", obs_if.cpu_reading_rf_data_a,
                     obs_if.cpu_reading_rf_data_b, 64'h10);
        end
        checks++;
        if (obs_if.cpu_reading_mux_1_out !== 64'h20) begin
            errors++;
            $display("FAIL add_mux1 got %h exp %h", obs_if.cpu_reading_mux_1_out, 64'h20);
        end
    endtask

    task automatic test_arith();
        logic [63:0] exp_regs [6];
        exp_regs = '{64'h0, 64'h10, 64'h20, 64'h10, 64'h15, 64'h12};
        step();
        checks++;
        if (obs_if.cpu_reading_rf_data_a !== 64'h20 || obs_if.cpu_reading_mux_1_out !== 64'h10) begin
            errors++;
            $display("FAIL sub_view got a=%h r=%h exp a=20 r=10", obs_if.cpu_reading_rf_data_a,
                     obs_if.cpu_reading_mux_1_out);
        end
        step();
        checks++;
        if (obs_if.cpu_reading_mux_1_out !== 64'h15) begin
            errors++;
            $display("FAIL addi_view got %h exp %h", obs_if.cpu_reading_mux_1_out, 64'h15);
        end
        step();
        checks++;
        if (obs_if.cpu_reading_mux_1_out !== 64'h12) begin
            errors++;
            $display("FAIL addim3_view got %h exp %h", obs_if.cpu_reading_mux_1_out, 64'h12);
        end
        step();
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h18 || obs_if.cpu_reading_im_instr !== 32'h00000013) begin
            errors++;
            $display("FAIL nop_fetch got pc=%h i=%h exp pc=18 i=00000013",
                     obs_if.cpu_reading_pc_addr, obs_if.cpu_reading_im_instr);
        end
        step();
        for (int r = 1; r < 6; r++) begin
            checks++;
            if (dut.rf[r] !== exp_regs[r]) begin
                errors++;
                $display("FAIL reg_x%0d got %h exp %h", r, dut.rf[r], exp_regs[r]);
            end
        end
        checks++;
        if (dut.dmem[2] !== 64'h10 || dut.rf[6] !== 64'h0) begin
            errors++;
            $display("FAIL nop_nowrite got ram2=%h x6=%h exp 10/0", dut.dmem[2], dut.rf[6]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(); step(); step(); step();
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h10) begin
            errors++;
            $display("FAIL pre_rst_pc got %h exp %h", obs_if.cpu_reading_pc_addr, 64'h10);
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h0) begin
            errors++;
            $display("FAIL async_rst_pc got %h exp %h", obs_if.cpu_reading_pc_addr, 64'h0);
        end
        for (int r = 1; r < 6; r++) begin
            checks++;
            if (dut.rf[r] !== 64'h0) begin
                errors++;
                $display("FAIL async_rst_x%0d got %h exp 0", r, dut.rf[r]);
            end
        end
        checks++;
        if (dut.dmem[2] !== 64'h20) begin
            errors++;
            $display("FAIL async_rst_ram2 got %h exp %h", dut.dmem[2], 64'h20);
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
        step(); step(); step();
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'hC || obs_if.cpu_reading_mux_1_out !== 64'h10
            || dut.dmem[2] !== 64'h10) begin
            errors++;
            $display("FAIL rerun got pc=%h r=%h ram2=%h exp C/10/10", obs_if.cpu_reading_pc_addr,
                     obs_if.cpu_reading_mux_1_out, dut.dmem[2]);
        end
    endtask

    task automatic test_beq();
        do_reset();
        step(); step();
        force dut.instr = 32'hFE000CE3;
        #1;
        checks++;
        if (obs_if.cpu_reading_mux_2_out !== 64'h0) begin
            errors++;
            $display("FAIL beq_taken_mux2 got %h exp %h", obs_if.cpu_reading_mux_2_out, 64'h0);
        end
        step();
        release dut.instr;
        #1;
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'h0 || dut.rf[2] !== 64'h0) begin
            errors++;
            $display("FAIL beq_taken_pc got pc=%h x2=%h exp 0/0", obs_if.cpu_reading_pc_addr,
                     dut.rf[2]);
        end
        step(); step();
        force dut.instr = 32'hFE008CE3;
        #1;
        checks++;
        if (obs_if.cpu_reading_mux_2_out !== 64'hC) begin
            errors++;
            $display("FAIL beq_not_taken_mux2 got %h exp %h", obs_if.cpu_reading_mux_2_out, 64'hC);
        end
        step();
        release dut.instr;
        #1;
        checks++;
        if (obs_if.cpu_reading_pc_addr !== 64'hC) begin
            errors++;
            $display("FAIL beq_not_taken_pc got %h exp %h", obs_if.cpu_reading_pc_addr, 64'hC);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cpu_rst = 1'b1;
        test_reset();
        test_ld_sd();
        test_arith();
        test_mid_reset();
        test_beq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
